// File: rtl/fwd_hazard_pkg.sv
// Shared types for the forwarding / hazard controller.
// Optional perf counters are enabled with FWD_HAZARD_PERF_EN.
package fwd_hazard_pkg;

    localparam int FWD_RF  = 0;
    localparam int RD_MAXW = 8;

    typedef struct packed {
        logic               valid;
        logic               regwrite;
        logic               is_load;
        logic [RD_MAXW-1:0] rd;
    } shadow_entry_t;

    function automatic int sel_width(input int depth);
        return (depth > 2) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fwd_src_match.sv
// Per-operand producer search: youngest matching writer wins,
// and any matching load still too young to forward flags a hazard.
module fwd_src_match
    import fwd_hazard_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int DEPTH      = 3,
    parameter int LOAD_STAGE = 2,
    parameter int SELW       = 2
) (
    input  logic [REG_AW-1:0]        src,
    input  logic                     use_src,
    input  shadow_entry_t [DEPTH-2:0] ent,
    output logic [SELW-1:0]          sel,
    output logic                     hit,
    output logic                     load_haz
);

    always_comb begin
        sel      = '0;
        hit      = 1'b0;
        load_haz = 1'b0;
        // Walk oldest to youngest so the youngest match overwrites.
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (use_src && (src != '0) &&
                ent[j].valid && ent[j].regwrite &&
                (ent[j].rd == RD_MAXW'(src))) begin
                sel = SELW'(j + 1);
                hit = 1'b1;
                if (ent[j].is_load && ((j + 1) < LOAD_STAGE)) begin
                    load_haz = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding select and load-use stall controller for the EX stage.
// Define FWD_HAZARD_PERF_EN to add saturating stall/forward counters.
module fwd_hazard_ctrl
    import fwd_hazard_pkg::*;
#(
    parameter int  REG_AW     = 5,
    parameter int  DEPTH      = 3,
    parameter int  LOAD_STAGE = 2,
    localparam int SELW       = sel_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_is_load,
    input  logic              flush,
    input  logic              freeze,
    output logic              stall,
    output logic [SELW-1:0]   fwd_a,
    output logic [SELW-1:0]   fwd_b,
    output logic              ex_valid
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       fwd_cnt
`endif
);

    localparam int N = DEPTH - 1;

    // The last stage is never stored: the register file writes
    // through, so its tag can never influence a select or stall.
    shadow_entry_t [N-1:0] s_q, s_d;
    shadow_entry_t         id_ent;

    logic [SELW-1:0] fwd_a_q, fwd_a_d;
    logic [SELW-1:0] fwd_b_q, fwd_b_d;
    logic [SELW-1:0] sel_a, sel_b;
    logic            hit_a, hit_b;
    logic            haz_a, haz_b;
    logic            bubble;

    fwd_src_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .LOAD_STAGE(LOAD_STAGE),
        .SELW      (SELW)
    ) u_match_a (
        .src     (id_rs1),
        .use_src (id_use_rs1),
        .ent     (s_q),
        .sel     (sel_a),
        .hit     (hit_a),
        .load_haz(haz_a)
    );

    fwd_src_match #(
        .REG_AW    (REG_AW),
        .DEPTH     (DEPTH),
        .LOAD_STAGE(LOAD_STAGE),
        .SELW      (SELW)
    ) u_match_b (
        .src     (id_rs2),
        .use_src (id_use_rs2),
        .ent     (s_q),
        .sel     (sel_b),
        .hit     (hit_b),
        .load_haz(haz_b)
    );

    always_comb begin
        id_ent.valid    = id_valid & ~flush;
        id_ent.regwrite = id_regwrite;
        id_ent.is_load  = id_is_load;
        id_ent.rd       = RD_MAXW'(id_rd);

        stall  = ~freeze & ~flush & id_valid & (haz_a | haz_b);
        bubble = stall | flush;

        s_d     = s_q;
        fwd_a_d = fwd_a_q;
        fwd_b_d = fwd_b_q;
        if (!freeze) begin
            for (int j = N - 1; j > 0; j--) begin
                s_d[j] = s_q[j-1];
            end
            s_d[0]  = bubble ? '0 : id_ent;
            fwd_a_d = (bubble || !hit_a) ? SELW'(FWD_RF) : sel_a;
            fwd_b_d = (bubble || !hit_b) ? SELW'(FWD_RF) : sel_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q     <= '0;
            fwd_a_q <= '0;
            fwd_b_q <= '0;
        end else begin
            s_q     <= s_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a    = fwd_a_q;
    assign fwd_b    = fwd_b_q;
    assign ex_valid = s_q[0].valid;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] fwd_cnt_q, fwd_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        fwd_cnt_d   = fwd_cnt_q;
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (!freeze && !bubble && (hit_a || hit_b) &&
            (fwd_cnt_q != '1)) begin
            fwd_cnt_d = fwd_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            fwd_cnt_q   <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            fwd_cnt_q   <= fwd_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign fwd_cnt   = fwd_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Scoreboard bench for fwd_hazard_ctrl: directed hazard cases,
// then randomized traffic against an instruction-level model.
module tb_fwd_hazard_ctrl;

    localparam int AW    = 5;
    localparam int DEPTH = 3;
    localparam int LS    = 2;
    localparam int SW    = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1, id_rs2, id_rd;
    logic          id_use_rs1, id_use_rs2;
    logic          id_regwrite, id_is_load;
    logic          flush, freeze;
    logic          stall;
    logic [SW-1:0] fwd_a, fwd_b;
    logic          ex_valid;
`ifdef FWD_HAZARD_PERF_EN
    logic [31:0]   stall_cnt, fwd_cnt;
`endif

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(
        .REG_AW    (AW),
        .DEPTH     (DEPTH),
        .LOAD_STAGE(LS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_rd      (id_rd),
        .id_regwrite(id_regwrite),
        .id_is_load (id_is_load),
        .flush      (flush),
        .freeze     (freeze),
        .stall      (stall),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .ex_valid   (ex_valid)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cnt  (stall_cnt),
        .fwd_cnt    (fwd_cnt)
`endif
    );

    typedef struct {
        int fa;
        int fb;
        bit ev;
        bit st;
    } exp_t;

    typedef struct {
        bit v;
        int rd;
        bit rw;
        bit ld;
    } ins_t;

    exp_t sbq[$];
    ins_t pipe[$];
    int   m_fa, m_fb;
    bit   m_ev;
    bit   last_st;
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: pipe[age] is the instruction age+1 cycles past decode.
    function automatic int pick(input int src, input bit u);
        if (!u || src == 0) return 0;
        for (int age = 0; age < DEPTH - 1; age++) begin
            if (pipe[age].v && pipe[age].rw && pipe[age].rd == src)
                return age + 1;
        end
        return 0;
    endfunction

    function automatic bit load_wait(input int src, input bit u);
        if (!u || src == 0) return 0;
        for (int age = 0; age < DEPTH - 1; age++) begin
            if (pipe[age].v && pipe[age].rw && pipe[age].rd == src)
                if (pipe[age].ld && (age + 1) < LS) return 1;
        end
        return 0;
    endfunction

    function automatic void model_reset();
        ins_t z;
        z = '{v: 0, rd: 0, rw: 0, ld: 0};
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(z);
        m_fa    = 0;
        m_fb    = 0;
        m_ev    = 0;
        last_st = 0;
    endfunction

    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("sb_fwd_a", int'(fwd_a), e.fa);
            chk("sb_fwd_b", int'(fwd_b), e.fb);
            chk("sb_ex_valid", int'(ex_valid), int'(e.ev));
            chk("sb_stall", int'(stall), int'(e.st));
        end
    end

    task automatic op(input bit v, input int rs1, input bit u1,
                      input int rs2, input bit u2, input int rd,
                      input bit rw, input bit ld, input bit fl = 0,
                      input bit fz = 0, input int exp_st = -1);
        bit   st;
        bit   kill;
        ins_t ni;
        id_valid    = v;
        id_rs1      = AW'(rs1);
        id_rs2      = AW'(rs2);
        id_use_rs1  = u1;
        id_use_rs2  = u2;
        id_rd       = AW'(rd);
        id_regwrite = rw;
        id_is_load  = ld;
        flush       = fl;
        freeze      = fz;
        st = v && !fl && !fz &&
             (load_wait(rs1, u1) || load_wait(rs2, u2));
        sbq.push_back('{fa: m_fa, fb: m_fb, ev: m_ev, st: st});
        if (!fz) begin
            kill = st || fl;
            if (kill) ni = '{v: 0, rd: 0, rw: 0, ld: 0};
            else      ni = '{v: v, rd: rd, rw: rw, ld: ld};
            m_fa = kill ? 0 : pick(rs1, u1);
            m_fb = kill ? 0 : pick(rs2, u2);
            pipe.push_front(ni);
            void'(pipe.pop_back());
            m_ev = ni.v;
        end
        last_st = st;
        @(negedge clk);
        if (exp_st >= 0) chk("dir_stall", int'(stall), exp_st);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        id_valid    = 0;
        id_rs1      = '0;
        id_rs2      = '0;
        id_use_rs1  = 0;
        id_use_rs2  = 0;
        id_rd       = '0;
        id_regwrite = 0;
        id_is_load  = 0;
        flush       = 0;
        freeze      = 0;
        #2;
        rst_n = 0;
        #1;
        chk("rst_fwd_a", int'(fwd_a), 0);
        chk("rst_fwd_b", int'(fwd_b), 0);
        chk("rst_ex_valid", int'(ex_valid), 0);
        chk("rst_stall", int'(stall), 0);
        sbq.delete();
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs1, rs2, rd;
        bit v, u1, u2, rw, ld, fl, fz;
        rst_n = 1;
        do_reset();

        // back-to-back ALU dependency
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 5, 1, 1, 1, 6, 1, 0, 0, 0, 0);
        chk("b2b_fwd_a", int'(fwd_a), 1);
        chk("b2b_fwd_b", int'(fwd_b), 0);

        // one instruction gap
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(0, 0, 0, 0, 0, 0, 0, 0);
        op(1, 2, 1, 5, 1, 7, 1, 0, 0, 0, 0);
        chk("gap_fwd_a", int'(fwd_a), 0);
        chk("gap_fwd_b", int'(fwd_b), 2);

        // two writers, youngest wins
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 3, 1, 4, 1, 5, 1, 0);
        op(1, 5, 1, 0, 0, 10, 1, 0);
        chk("young_fwd_a", int'(fwd_a), 1);

        // load-use: one bubble then forward from stage 2
        op(1, 1, 1, 0, 0, 8, 1, 1);
        op(1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 1);
        chk("lu_bubble_ev", int'(ex_valid), 0);
        chk("lu_bubble_fa", int'(fwd_a), 0);
        op(1, 8, 1, 8, 1, 9, 1, 0, 0, 0, 0);
        chk("lu_fwd_a", int'(fwd_a), 2);
        chk("lu_fwd_b", int'(fwd_b), 2);
        chk("lu_ev", int'(ex_valid), 1);

        // x0 never forwarded
        op(1, 1, 1, 2, 1, 0, 1, 0);
        op(1, 0, 1, 0, 1, 3, 1, 0);
        chk("x0_fwd_a", int'(fwd_a), 0);

        // regwrite=0 producer
        op(1, 1, 1, 2, 1, 11, 0, 0);
        op(1, 11, 1, 11, 1, 3, 1, 0);
        chk("norw_fwd_a", int'(fwd_a), 0);
        chk("norw_fwd_b", int'(fwd_b), 0);

        // flush during load-use
        op(1, 1, 1, 0, 0, 12, 1, 1);
        op(1, 12, 1, 1, 1, 13, 1, 0, 1, 0, 0);
        chk("fl_fwd_a", int'(fwd_a), 0);
        chk("fl_ev", int'(ex_valid), 0);

        // freeze holds everything for 3 cycles
        op(1, 1, 1, 2, 1, 5, 1, 0);
        op(1, 5, 1, 5, 1, 15, 1, 0);
        for (int i = 0; i < 3; i++) begin
            op(1, 15, 1, 1, 1, 4, 1, 1, 0, 1, 0);
            chk("frz_fwd_a", int'(fwd_a), 1);
            chk("frz_fwd_b", int'(fwd_b), 1);
            chk("frz_ev", int'(ex_valid), 1);
        end
        op(1, 5, 1, 15, 1, 16, 1, 0);
        chk("unfrz_fwd_a", int'(fwd_a), 2);
        chk("unfrz_fwd_b", int'(fwd_b), 1);

        // randomized traffic, with a mid-stream reset
        rs1 = 0; rs2 = 0; rd = 0;
        v = 0; u1 = 0; u2 = 0; rw = 0; ld = 0;
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            if (!last_st) begin
                v  = ($urandom % 8) != 0;
                rs1 = $urandom % 8;
                rs2 = $urandom % 8;
                u1 = ($urandom % 4) != 0;
                u2 = ($urandom % 2) != 0;
                rd = $urandom % 8;
                rw = ($urandom % 5) != 0;
                ld = ($urandom % 3) == 0;
            end
            fl = ($urandom % 8) == 0;
            fz = ($urandom % 8) == 0;
            op(v, rs1, u1, rs2, u2, rd, rw, ld, fl, fz);
        end

        @(negedge clk);
        #1;
        chk("sb_drain", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_ctrl.md
Name: fwd_hazard_ctrl

Overview:
- Parametrised forwarding and hazard controller for the in-order integer pipeline.
- It owns a shadow pipeline of destination tags (rd, regwrite, is_load) for every stage after decode.
- Each cycle it compares the decode-stage sources against in-flight producers and issues registered forward selects for EX.
- It raises a load-use stall and inserts bubbles, so the datapath no longer needs its own EX/MEM and MEM/WB control copies for hazards.

Parameters:
- REG_AW, 5, register index width; index 0 is hardwired zero and never forwarded.
- DEPTH, 3, tracked stages after decode (s0=EX, s1=MEM, s2=WB); minimum 2.
- LOAD_STAGE, 2, stage index whose output first carries load data; must satisfy 1 <= LOAD_STAGE <= DEPTH-1.
- SELW, $clog2(DEPTH), forward-select width (derived, not overridable).

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_rs1  in  REG_AW  source 1 index.
- id_rs2  in  REG_AW  source 2 index.
- id_use_rs1  in  1  instruction reads rs1.
- id_use_rs2  in  1  instruction reads rs2.
- id_rd  in  REG_AW  destination index.
- id_regwrite  in  1  instruction writes rd.
- id_is_load  in  1  instruction is a load.
- flush  in  1  branch resolved taken in EX; kill decode slot.
- freeze  in  1  external stall (memory wait); hold entire pipeline.
- stall  out  1  hold PC and IF/ID, bubble into EX (combinational).
- fwd_a  out  SELW  EX operand A select, registered.
- fwd_b  out  SELW  EX operand B select, registered.
- ex_valid  out  1  shadow s0 valid, registered.

Behaviour:
- Reset: all shadow entries invalid with rd=0. fwd_a=fwd_b=0, ex_valid=0, stall=0. Reset is asynchronous, so asserting it mid-operation discards all in-flight tags immediately.
- Select encoding: 0 = register file value. k (1..DEPTH-1) = result bus at the output of stage k during the EX cycle.
- Match rule, evaluated in decode against current entries s[j], j = 0..DEPTH-2:
  - s[j] is valid and regwrite=1.
  - s[j].rd equals the source index.
  - The source index is not 0.
  - The corresponding use flag is set.
- Producers in s[DEPTH-1] are excluded because the register file writes through in the same cycle.
- Priority: the youngest match (lowest j) wins; the select becomes j+1.
- Load-use: stall=1 when id_valid and any used source matches an s[j] with is_load=1 and j+1 < LOAD_STAGE. This is evaluated on every matching entry, not only the winner.
- Advance with no freeze and no stall:
  - s[j+1] <= s[j].
  - s0 <= decode tags, with valid = id_valid & ~flush.
  - fwd_a/fwd_b <= computed selects, or 0 if flush.
- Stall with no freeze: the shadow pipeline advances, s0 <= bubble (valid=0), fwd_a/fwd_b <= 0, and decode is held. The stall clears once the load reaches a stage where j+1 >= LOAD_STAGE. With defaults this costs exactly 1 bubble.
- Freeze: all registers hold and stall is forced to 0. Freeze has priority over everything except reset.
- Flush and stall in the same cycle: flush wins, s0 <= bubble, stall=0.
- Latency: selects appear one cycle after decode, aligned with the instruction's EX cycle.

Optional Feature:
- Macro: FWD_HAZARD_PERF_EN.
- When defined, adds two outputs:
  - stall_cnt (32 bits): counts cycles with stall=1 and freeze=0; saturates at all-ones; cleared by reset.
  - fwd_cnt (32 bits): counts advance cycles where fwd_a or fwd_b loaded a nonzero select; saturates at all-ones; cleared by reset.
- When not defined, neither port nor its counter logic exists.

Decomposition:
- Package fwd_hazard_pkg holds:
  - FWD_RF = 0 constant.
  - shadow_entry_t struct: valid, regwrite, is_load, rd.
  - Helper for select width.
- Sub-module fwd_src_match: one instance per operand. It takes source index, use flag and the entry array, and returns the select, a hit flag and a load-hazard flag.

Test Plan:
- add x5 then add x6,x5,x1 back to back -> next cycle fwd_a=1, fwd_b=0, stall never asserted.
- add x5; nop; sub x7,x2,x5 -> fwd_b=2.
- Writers of x5 in both s0 and s1 -> select=1 (youngest wins).
- lw x8; add x9,x8,x8 -> stall=1 for exactly 1 cycle, ex_valid=0 in the bubble cycle, then fwd_a=fwd_b=2.
- Producer writes x0; consumer reads x0 -> fwd_a=0.
- Producer with regwrite=0 and a matching rd -> select=0.
- flush asserted during the load-use stall -> stall drops the same cycle, s0 becomes a bubble, selects=0.
- freeze held 3 cycles mid-sequence -> outputs and shadow state unchanged; rst_n pulsed mid-stream -> all outputs 0 asynchronously.
